flashing_light_multi_v2: RTL
============================

// Module: flashing_light_multi_v2
// PURPOSE
//  AXI4-Lite slave PL peripheral driving NUM_CH independent LED outputs.
//  Each channel blinks with a software-programmed PERIOD and ON_TIME, in clock cycles.
//  New PERIOD/ON_TIME values take effect glitch-free at the channel's next wrap.
//  Sits behind the PS GP port via the AXI interconnect, like the single-light IP it replaces.
// PARAMETERS
//  C_S_AXI_DATA_WIDTH  32  AXI data width; only 32 is supported.
//  C_S_AXI_ADDR_WIDTH  7   byte-address width; covers 0x00..0x4F.
//  NUM_CH              4   channel count, 1..8.
//  CNT_WIDTH           32  width of PERIOD, ON_TIME and the per-channel counter, 1..32.
// PORTS
//  S_AXI_ACLK     in   1     single clock
//  S_AXI_ARESETN  in   1     synchronous reset, active-low
//  S_AXI_AWADDR   in   7     write address; bits [1:0] ignored
//  S_AXI_AWPROT   in   3     ignored
//  S_AXI_AWVALID  in   1     /  S_AXI_AWREADY out 1
//  S_AXI_WDATA    in   32    write data
//  S_AXI_WSTRB    in   4     byte enables, honoured per byte
//  S_AXI_WVALID   in   1     /  S_AXI_WREADY  out 1
//  S_AXI_BRESP    out  2     /  S_AXI_BVALID  out 1  /  S_AXI_BREADY in 1
//  S_AXI_ARADDR   in   7     /  S_AXI_ARPROT  in  3 (ignored)
//  S_AXI_ARVALID  in   1     /  S_AXI_ARREADY out 1
//  S_AXI_RDATA    out  32    /  S_AXI_RRESP   out 2
//  S_AXI_RVALID   out  1     /  S_AXI_RREADY  in  1
//  led_o          out  NUM_CH  registered LED drive, bit i = channel i
// BEHAVIOUR
//  Reset: all registers, counters, shadows, led_o, *READY, *VALID, RDATA and *RESP are 0.
//  Register map:
//   0x00 CTRL     bit0 GEN (global enable, RW); bit1 RESTART (W1, self-clears, reads 0).
//   0x04 CH_EN    bits[NUM_CH-1:0] per-channel enable (RW); upper bits read 0.
//   0x08 STATUS   RO, = led_o zero-extended.
//   0x0C ID       RO, = {16'hF1A5, 8'h02, 8'(NUM_CH)}.
//   0x10+8i PERIOD[i], 0x14+8i ON_TIME[i], RW, CNT_WIDTH bits; upper bits read 0.
//  Write channel:
//   - AWREADY=WREADY=1 for exactly one cycle when AWVALID&WVALID&!BVALID; never one without the other.
//   - The register updates on that edge. BVALID rises the next cycle and holds until BREADY.
//   - At most one write is outstanding.
//  Read channel:
//   - ARREADY=1 for one cycle when ARVALID&!RVALID&!ARREADY.
//   - RDATA is captured on that edge; RVALID rises the next cycle and holds with stable RDATA until RREADY.
//  Responses:
//   - Mapped address -> OKAY (2'b00).
//   - Unmapped address (incl. channels >= NUM_CH) -> SLVERR (2'b10). Writes are ignored; reads return 0.
//  Simultaneous read and write: both proceed; a read accepted in the same cycle as a write to that register returns the pre-write value.
//  Channel i is active when GEN & CH_EN[i] & (shadow PERIOD != 0).
//  Inactive channel:
//   - cnt = 0; shadow PERIOD/ON_TIME copy the live registers every cycle; led_o[i] is 0 one cycle later.
//  Active channel:
//   - cnt += 1 each cycle. At cnt == shadowPERIOD-1, cnt wraps to 0 and the shadows reload from the live registers.
//  led_o[i] <= active & (cnt < shadowON); one cycle after cnt.
//   - ON_TIME >= PERIOD -> solid on. ON_TIME = 0 -> solid off.
//  RESTART: on its write edge, all counters go to 0 and all shadows reload. It is applied after any same-cycle wrap.
//  Counter is CNT_WIDTH wide; PERIOD = 2^CNT_WIDTH-1 wraps correctly with no overflow.
//  Reset mid-transaction: a pending BVALID/RVALID is dropped; the master must reissue.
// TESTING
//  1. Reset, then read all addresses -> RDATA 0 except ID = 0xF1A50204; RRESP OKAY; led_o = 0.
//  2. PERIOD0=4, ON0=1, CH_EN=1, CTRL=1 -> led_o[0] pattern 1,0,0,0 repeating; other bits stay 0.
//  3. Running PERIOD0=4, ON0=1; write PERIOD0=8, ON0=4 mid-cycle -> current 4-cycle period completes, then 11110000 repeats; no runt pulse.
//  4. ON1=10 with PERIOD1=5 -> led_o[1] constant 1. ON1=0 -> constant 0. PERIOD1=0 -> 0 and cnt held at 0.
//  5. Write 0x60 and 0x30 (NUM_CH=4) -> BRESP=SLVERR, no state change; read 0x30 -> RDATA 0, RRESP=SLVERR.
//  6. WSTRB=4'b0001 writing 0xAABBCCDD to PERIOD2=0x11223344 -> reads 0x112233DD.
//     Also: BREADY held low 20 cycles -> BVALID held, second AW/W stalled (AWREADY=0).

Source files
------------

// File: rtl/flashing_light_multi_v2.sv
// AXI4-Lite slave driving NUM_CH independently programmable blinking LEDs.
// PERIOD/ON_TIME are double-buffered into shadows that reload only at each channel's wrap.
module flashing_light_multi_v2 #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 7,
  parameter int NUM_CH             = 4,
  parameter int CNT_WIDTH          = 32
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [NUM_CH-1:0]               led_o
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int WORD_W = C_S_AXI_ADDR_WIDTH - 2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic                 aw_rdy, b_valid, ar_rdy, r_valid;
  logic [1:0]           b_resp, r_resp;
  logic [DW-1:0]        r_data;
  logic                 gen;
  logic [NUM_CH-1:0]    ch_en;
  logic [CNT_WIDTH-1:0] per_q  [NUM_CH];
  logic [CNT_WIDTH-1:0] on_q   [NUM_CH];
  logic [CNT_WIDTH-1:0] sh_per [NUM_CH];
  logic [CNT_WIDTH-1:0] sh_on  [NUM_CH];
  logic [CNT_WIDTH-1:0] cnt    [NUM_CH];
  logic [NUM_CH-1:0]    active;
  logic [WORD_W-1:0]    wr_word, rd_word;
  logic                 wr_fire, rd_fire, restart;
  logic [DW-1:0]        wr_new, rd_val;
  logic                 unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  function automatic logic is_mapped(input logic [WORD_W-1:0] w);
    return int'(w) < 4 + 2 * NUM_CH;
  endfunction

  function automatic logic [DW-1:0] reg_value(input logic [WORD_W-1:0] w);
    logic [DW-1:0] v;
    v = '0;
    case (w)
      WORD_W'(0): v[0] = gen;
      WORD_W'(1): v[NUM_CH-1:0] = ch_en;
      WORD_W'(2): v[NUM_CH-1:0] = led_o;
      WORD_W'(3): v = {16'hF1A5, 8'h02, 8'(NUM_CH)};
      default: begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (w == WORD_W'(4 + 2 * i)) v[CNT_WIDTH-1:0] = per_q[i];
          if (w == WORD_W'(5 + 2 * i)) v[CNT_WIDTH-1:0] = on_q[i];
        end
      end
    endcase
    return v;
  endfunction

  // Handshakes: a transfer happens on the edge where VALID and READY are both high.
  // AW and W are accepted together, one write at a time, never while B is pending;
  // B and R hold VALID (and their payload) stable until the master's READY.
  assign wr_word = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_word = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign wr_fire = aw_rdy & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire = ar_rdy & S_AXI_ARVALID;

  always_comb begin
    wr_new = reg_value(wr_word);
    for (int b = 0; b < DW / 8; b++) begin
      if (S_AXI_WSTRB[b]) wr_new[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
    end
  end

  assign rd_val  = is_mapped(rd_word) ? reg_value(rd_word) : '0;
  assign restart = wr_fire & (wr_word == WORD_W'(0)) & wr_new[1];

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      aw_rdy  <= 1'b0;
      b_valid <= 1'b0;
      b_resp  <= RESP_OKAY;
    end else begin
      aw_rdy <= S_AXI_AWVALID & S_AXI_WVALID & ~b_valid & ~aw_rdy;
      if (wr_fire) begin
        b_valid <= 1'b1;
        b_resp  <= is_mapped(wr_word) ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_BREADY) begin
        b_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      ar_rdy  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_resp  <= RESP_OKAY;
    end else begin
      ar_rdy <= S_AXI_ARVALID & ~r_valid & ~ar_rdy;
      if (rd_fire) begin
        r_valid <= 1'b1;
        r_data  <= rd_val;
        r_resp  <= is_mapped(rd_word) ? RESP_OKAY : RESP_SLVERR;
      end else if (S_AXI_RREADY) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Unmapped and read-only words match none of the cases below, so writes to them drop.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      gen   <= 1'b0;
      ch_en <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        per_q[i] <= '0;
        on_q[i]  <= '0;
      end
    end else if (wr_fire) begin
      if (wr_word == WORD_W'(0)) gen <= wr_new[0];
      if (wr_word == WORD_W'(1)) ch_en <= wr_new[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_word == WORD_W'(4 + 2 * i)) per_q[i] <= wr_new[CNT_WIDTH-1:0];
        if (wr_word == WORD_W'(5 + 2 * i)) on_q[i]  <= wr_new[CNT_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      active[i] = gen & ch_en[i] & (sh_per[i] != '0);
    end
  end

  // Restart and wrap both zero the counter and reload the shadows, so their order is moot.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      led_o <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]    <= '0;
        sh_per[i] <= '0;
        sh_on[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        led_o[i] <= active[i] & (cnt[i] < sh_on[i]);
        if (restart || !active[i] || cnt[i] == sh_per[i] - CNT_ONE) begin
          cnt[i]    <= '0;
          sh_per[i] <= per_q[i];
          sh_on[i]  <= on_q[i];
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  assign S_AXI_AWREADY = aw_rdy;
  assign S_AXI_WREADY  = aw_rdy;
  assign S_AXI_BVALID  = b_valid;
  assign S_AXI_BRESP   = b_resp;
  assign S_AXI_ARREADY = ar_rdy;
  assign S_AXI_RVALID  = r_valid;
  assign S_AXI_RDATA   = r_data;
  assign S_AXI_RRESP   = r_resp;

endmodule
